// File: rtl/pixel_fb_pkg.sv
// Shared geometry, frame-buffer pixel record and output-stage states for the pixel frame-buffer writer.
// Build option: PIXEL_FB_WRITER_STATS_EN (consumed by pixel_fb_writer).
package pixel_fb_pkg;

    localparam int X_SCREEN_PIXELS = 160;
    localparam int Y_SCREEN_PIXELS = 120;
    localparam int FB_ADDR_WIDTH   = 15;
    localparam int COLOUR_WIDTH    = 3;

    localparam logic [7:0] X_LIMIT = 8'(X_SCREEN_PIXELS);
    localparam logic [6:0] Y_LIMIT = 7'(Y_SCREEN_PIXELS);

    typedef struct packed {
        logic [FB_ADDR_WIDTH-1:0] addr;
        logic [COLOUR_WIDTH-1:0]  colour;
    } fb_pixel_t;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_VALID = 1'b1
    } fb_state_e;

    // Row-major linear address; only ever called for on-screen pixels, so it cannot wrap.
    function automatic logic [FB_ADDR_WIDTH-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
        return FB_ADDR_WIDTH'(y) * FB_ADDR_WIDTH'(X_SCREEN_PIXELS) + FB_ADDR_WIDTH'(x);
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with first-word-fall-through read; push when full and pop when empty are ignored.
// Latency 1 cycle push-to-visible; power-of-two DEPTH so pointers wrap naturally.
module pixel_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dat   = r_mem[r_rd_ptr];

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (w_push) r_mem[r_wr_ptr] <= i_dat;
    end

endmodule

// File: rtl/pixel_fb_writer.sv
// Clips the plot stream, converts (X,Y) to a frame-buffer address, buffers and issues stallable writes.
// Build option PIXEL_FB_WRITER_STATS_EN adds a saturating dropped-pixel counter on oDropCount.
module pixel_fb_writer
    import pixel_fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic [7:0]               iX,
    input  logic [6:0]               iY,
    input  logic [COLOUR_WIDTH-1:0]  iColour,
    input  logic                     iPlot,
    output logic                     oFull,
    output logic                     oEmpty,
    output logic                     oOverflow,
    output logic [FB_ADDR_WIDTH-1:0] oWrAddr,
    output logic [COLOUR_WIDTH-1:0]  oWrData,
    output logic                     oWrEn,
    input  logic                     iWrReady,
`ifdef PIXEL_FB_WRITER_STATS_EN
    output logic [15:0]              oDropCount,
`endif
    output logic                     oIdle
);
    fb_state_e                r_state;
    logic [FB_ADDR_WIDTH-1:0] r_wr_addr;
    logic [COLOUR_WIDTH-1:0]  r_wr_data;
    logic                     r_overflow;

    logic      w_onscreen;
    logic      w_full;
    logic      w_empty;
    logic      w_push;
    logic      w_pop;
    logic      w_lost;
    fb_pixel_t w_push_dat;
    fb_pixel_t w_pop_dat;

    assign w_onscreen = (iX < X_LIMIT) && (iY < Y_LIMIT);
    assign w_push     = iPlot && w_onscreen && !w_full;
    assign w_lost     = iPlot && w_onscreen && w_full;
    assign w_push_dat = '{addr: fb_addr(iX, iY), colour: iColour};
    // The output register refills whenever it is free or being drained this cycle.
    assign w_pop      = !w_empty && ((r_state == S_IDLE) || iWrReady);

    pixel_fifo #(
        .WIDTH ($bits(fb_pixel_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .i_push  (w_push),
        .i_dat   (w_push_dat),
        .i_pop   (w_pop),
        .o_dat   (w_pop_dat),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state   <= S_IDLE;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (w_pop) begin
            r_state   <= S_VALID;
            r_wr_addr <= w_pop_dat.addr;
            r_wr_data <= w_pop_dat.colour;
        end else if (r_state == S_VALID && iWrReady) begin
            r_state   <= S_IDLE;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) r_overflow <= 1'b0;
        else         r_overflow <= r_overflow | w_lost;
    end

`ifdef PIXEL_FB_WRITER_STATS_EN
    logic [15:0] r_drop_count;
    logic        w_drop;

    assign w_drop = iPlot && (!w_onscreen || w_full);

    always_ff @(posedge Clock) begin
        if (!Resetn)                               r_drop_count <= '0;
        else if (w_drop && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 1'b1;
    end

    assign oDropCount = r_drop_count;
`endif

    assign oFull     = w_full;
    assign oEmpty    = w_empty;
    assign oOverflow = r_overflow;
    assign oWrAddr   = r_wr_addr;
    assign oWrData   = r_wr_data;
    assign oWrEn     = (r_state == S_VALID);
    assign oIdle     = w_empty && !oWrEn;

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Directed bench for pixel_fb_writer: expected writes are queued at plot time and matched at the memory port.
module tb_pixel_fb_writer;
    import pixel_fb_pkg::*;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic [7:0]  iX;
    logic [6:0]  iY;
    logic [2:0]  iColour;
    logic        iPlot;
    logic        oFull, oEmpty, oOverflow, oWrEn, oIdle;
    logic [14:0] oWrAddr;
    logic [2:0]  oWrData;
    logic        iWrReady;
`ifdef PIXEL_FB_WRITER_STATS_EN
    logic [15:0] oDropCount;
`endif

    int checks   = 0;
    int failures = 0;
    int writes   = 0;
    int mark;
    int guard;
    logic [14:0] last_addr;
    fb_pixel_t   q[$];
    fb_pixel_t   m_exp;

    pixel_fb_writer #(.FIFO_DEPTH(8)) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .iX         (iX),
        .iY         (iY),
        .iColour    (iColour),
        .iPlot      (iPlot),
        .oFull      (oFull),
        .oEmpty     (oEmpty),
        .oOverflow  (oOverflow),
        .oWrAddr    (oWrAddr),
        .oWrData    (oWrData),
        .oWrEn      (oWrEn),
        .iWrReady   (iWrReady),
`ifdef PIXEL_FB_WRITER_STATS_EN
        .oDropCount (oDropCount),
`endif
        .oIdle      (oIdle)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic plot(input int x, input int y, input int c, input bit accept);
        iX      = 8'(x);
        iY      = 7'(y);
        iColour = 3'(c);
        iPlot   = 1'b1;
        if (accept) q.push_back('{addr: 15'(y * 160 + x), colour: 3'(c)});
        tick();
        iPlot = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (!oIdle && n < budget) begin
            tick();
            n++;
        end
        check(tag, oIdle, 1);
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        tick();
        Resetn = 1'b1;
        q.delete();
    endtask

    // Memory-port monitor: a write is committed at the edge following a sample with oWrEn && iWrReady.
    always @(negedge Clock) begin
        if (Resetn && oWrEn && iWrReady) begin
            writes++;
            last_addr = oWrAddr;
            checks++;
            assert (q.size() != 0) else begin
                failures++;
                $error("FAIL wr_unexpected observed=%0d expected=none", oWrAddr);
            end
            if (q.size() != 0) begin
                m_exp = q.pop_front();
                check("wr_addr", 32'(oWrAddr), 32'(m_exp.addr));
                check("wr_data", 32'(oWrData), 32'(m_exp.colour));
            end
        end
    end

    initial begin
        Resetn = 1'b0; iX = '0; iY = '0; iColour = '0; iPlot = 1'b0; iWrReady = 1'b1;
        tick();
        tick();
        Resetn = 1'b1;

        // Reset state
        check("rst_wren", oWrEn, 0);
        check("rst_addr", oWrAddr, 0);
        check("rst_data", oWrData, 0);
        check("rst_empty", oEmpty, 1);
        check("rst_full", oFull, 0);
        check("rst_idle", oIdle, 1);
        check("rst_ovf", oOverflow, 0);
`ifdef PIXEL_FB_WRITER_STATS_EN
        check("rst_drops", oDropCount, 0);
`endif

        // Single pixel: write request appears the cycle after the edge following the push
        mark = writes;
        plot(5, 2, 3, 1'b1);
        check("single_wren_e0", oWrEn, 0);
        check("single_idle_e0", oIdle, 0);
        tick();
        check("single_wren_e1", oWrEn, 1);
        check("single_addr", oWrAddr, 325);
        check("single_data", oWrData, 3);
        tick();
        check("single_wren_e2", oWrEn, 0);
        check("single_idle_e2", oIdle, 1);
        check("single_count", writes - mark, 1);

        // Stalled 4x4 box: output register plus FIFO hold 9, remaining 7 are lost
        iWrReady = 1'b0;
        mark = writes;
        for (int i = 0; i < 16; i++) plot(10 + (i % 4), 10 + (i / 4), i % 8, i < 9);
        check("stall_full", oFull, 1);
        check("stall_ovf", oOverflow, 1);
        check("stall_wren", oWrEn, 1);
        check("stall_addr", oWrAddr, 1610);
        check("stall_nowrites", writes - mark, 0);
`ifdef PIXEL_FB_WRITER_STATS_EN
        check("stall_drops", oDropCount, 7);
`endif
        iWrReady = 1'b1;
        wait_idle("stall_drain_idle", 40);
        check("stall_count", writes - mark, 9);
        check("stall_queue", q.size(), 0);
        check("stall_ovf_sticky", oOverflow, 1);

        // Clip: off-screen pixels never reach the memory port
        do_reset();
        check("reset2_ovf", oOverflow, 0);
        mark = writes;
        plot(160, 0, 1, 1'b0);
        plot(0, 120, 2, 1'b0);
        tick();
        tick();
        check("clip_nowrite", writes - mark, 0);
        check("clip_empty", oEmpty, 1);
        check("clip_ovf", oOverflow, 0);
`ifdef PIXEL_FB_WRITER_STATS_EN
        check("clip_drops", oDropCount, 2);
`endif
        plot(159, 119, 5, 1'b1);
        wait_idle("corner_idle", 10);
        check("corner_count", writes - mark, 1);
        check("corner_addr", last_addr, 19199);

        // Full-screen clear with random memory stalls; plotting paced by oFull
        do_reset();
        mark = writes;
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                guard = 0;
                while (oFull && guard < 100) begin
                    iWrReady = 1'($urandom_range(0, 1));
                    tick();
                    guard++;
                end
                if (guard >= 100) check("clear_full_stuck", oFull, 0);
                iWrReady = 1'($urandom_range(0, 1));
                plot(x, y, 0, 1'b1);
            end
        end
        iWrReady = 1'b1;
        wait_idle("clear_idle", 40);
        check("clear_ovf", oOverflow, 0);
        check("clear_count", writes - mark, 19200);
        check("clear_queue", q.size(), 0);
        check("clear_last", last_addr, 19199);

        // Reset during a stalled write with the FIFO half full
        iWrReady = 1'b0;
        for (int i = 0; i < 5; i++) plot(20 + i, 30, 7, 1'b1);
        check("mid_wren_pre", oWrEn, 1);
        check("mid_empty_pre", oEmpty, 0);
        mark = writes;
        do_reset();
        check("mid_wren_post", oWrEn, 0);
        check("mid_empty_post", oEmpty, 1);
        check("mid_idle_post", oIdle, 1);
        check("mid_addr_post", oWrAddr, 0);
        iWrReady = 1'b1;
        plot(3, 4, 6, 1'b1);
        wait_idle("mid_new_idle", 10);
        check("mid_new_count", writes - mark, 1);
        check("mid_new_addr", last_addr, 643);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
